// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcode encoding, FSM states, opcode width.
package alu_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_SUB = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } alu_iter_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned-magnitude shift-add multiplier / restoring divider, one bit per cycle.
// The divide step is only built when ALU_ITER_DIV_EN is defined.
module alu_iter_muldiv #(
  parameter int WIDTH_P = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               div_i,
  input  logic               signed_i,
  input  logic [WIDTH_P-1:0] a_i,
  input  logic [WIDTH_P-1:0] b_i,
  output logic               done_o,
  output logic [WIDTH_P-1:0] hi_o,
  output logic [WIDTH_P-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH_P);

  logic [WIDTH_P-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH_P-1:0] abs_a, abs_b;
  logic [WIDTH_P:0]   acc;
`ifdef ALU_ITER_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH_P:0]   diff;
`endif

  assign abs_a  = (signed_i && a_i[WIDTH_P-1]) ? -a_i : a_i;
  assign abs_b  = (signed_i && b_i[WIDTH_P-1]) ? -b_i : b_i;
  assign done_o = busy_q && (cnt_q == '0);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    acc    = '0;
`ifdef ALU_ITER_DIV_EN
    div_d  = div_q;
    diff   = '0;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH_P - 1);
      hi_d   = '0;
      div_d  = div_i;
      // Divide: lo holds the dividend shifting out / quotient shifting in.
      lo_d   = div_i ? abs_a : abs_b;
      opnd_d = div_i ? abs_b : abs_a;
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
      if (div_q) begin
        acc  = {hi_q, lo_q[WIDTH_P-1]};
        diff = acc - {1'b0, opnd_q};
        if (acc >= {1'b0, opnd_q}) begin
          hi_d = diff[WIDTH_P-1:0];
          lo_d = {lo_q[WIDTH_P-2:0], 1'b1};
        end else begin
          hi_d = acc[WIDTH_P-1:0];
          lo_d = {lo_q[WIDTH_P-2:0], 1'b0};
        end
      end else begin
        acc          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        {hi_d, lo_d} = {acc, lo_q[WIDTH_P-1:1]};
      end
    end
`else
    // Without divide hardware a divide request never starts the engine.
    if (start_i && !div_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH_P - 1);
      hi_d   = '0;
      lo_d   = abs_b;
      opnd_d = abs_a;
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
      acc          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      {hi_d, lo_d} = {acc, lo_q[WIDTH_P-1:1]};
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
`ifdef ALU_ITER_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU top: FSM, handshake, single-cycle ops, sign fix-up and result register.
// Divide hardware is present only when ALU_ITER_DIV_EN is defined.
// Handshake: an op is taken on a clock edge where valid_i && ready_o; a result is held
// on result_o/err_o while valid_o is high and is consumed on an edge where ready_i is high.
module alu_iter import alu_pkg::*; #(
  parameter int WIDTH_P = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [OPCODE_W-1:0]  opcode_i,
  input  logic                 signed_i,
  input  logic [WIDTH_P-1:0]   operand_a_i,
  input  logic [WIDTH_P-1:0]   operand_b_i,
  output logic                 ready_o,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [2*WIDTH_P-1:0] result_o,
  output logic                 err_o,
  output logic [1:0]           state_o
);

  localparam int W = WIDTH_P;

  alu_iter_state_e state_q, state_d;
  logic [2*W-1:0]  result_q, result_d, sc_result, fix_result, prod_mag;
  logic            err_q, err_d, valid_q, valid_d, neg_q, neg_d;
  logic            sc_err, fix_err, accept, is_iter, md_start, md_done;
  logic [W:0]      ext_a, ext_b, arith;
  logic [W-1:0]    md_hi, md_lo;
  opcode_e         op_in;
`ifdef ALU_ITER_DIV_EN
  logic            div_q, div_d, rem_neg_q, rem_neg_d, bz_q, bz_d;
  logic [W-1:0]    a_q, a_d;
`endif

  assign op_in    = opcode_e'(opcode_i);
  assign ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i);
  assign accept   = valid_i && ready_o;
  assign md_start = accept && is_iter;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign err_o    = err_q;
  assign state_o  = state_q;
`ifdef ALU_ITER_DIV_EN
  assign is_iter  = (op_in == OP_MUL) || (op_in == OP_DIV);
`else
  assign is_iter  = (op_in == OP_MUL);
`endif

  // ADD/SUB return the exact arithmetic value: only an unsigned ADD is known non-negative.
  always_comb begin
    ext_a     = signed_i ? {operand_a_i[W-1], operand_a_i} : {1'b0, operand_a_i};
    ext_b     = signed_i ? {operand_b_i[W-1], operand_b_i} : {1'b0, operand_b_i};
    arith     = (op_in == OP_SUB) ? ext_a - ext_b : ext_a + ext_b;
    sc_result = '0;
    sc_err    = 1'b0;
    case (op_in)
      OP_ADD:  sc_result = signed_i ? {{(W-1){arith[W]}}, arith} : {{(W-1){1'b0}}, arith};
      OP_SUB:  sc_result = {{(W-1){arith[W]}}, arith};
      OP_AND:  sc_result = {{W{1'b0}}, operand_a_i & operand_b_i};
      OP_OR:   sc_result = {{W{1'b0}}, operand_a_i | operand_b_i};
      OP_XOR:  sc_result = {{W{1'b0}}, operand_a_i ^ operand_b_i};
      OP_DIV:  sc_err    = 1'b1;
      default: sc_result = '0;
    endcase
  end

  always_comb begin
    prod_mag   = {md_hi, md_lo};
    fix_result = neg_q ? -prod_mag : prod_mag;
    fix_err    = 1'b0;
`ifdef ALU_ITER_DIV_EN
    if (div_q) begin
      if (bz_q) begin
        fix_result = {a_q, {W{1'b1}}};
        fix_err    = 1'b1;
      end else begin
        fix_result = {rem_neg_q ? -md_hi : md_hi, neg_q ? -md_lo : md_lo};
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    err_d     = err_q;
    valid_d   = valid_q;
    neg_d     = neg_q;
`ifdef ALU_ITER_DIV_EN
    div_d     = div_q;
    rem_neg_d = rem_neg_q;
    bz_d      = bz_q;
    a_d       = a_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept && is_iter) begin
          state_d   = ST_ITER;
          valid_d   = 1'b0;
          neg_d     = signed_i && (operand_a_i[W-1] ^ operand_b_i[W-1]);
`ifdef ALU_ITER_DIV_EN
          div_d     = (op_in == OP_DIV);
          rem_neg_d = signed_i && operand_a_i[W-1];
          bz_d      = (operand_b_i == '0);
          a_d       = operand_a_i;
`endif
        end else if (accept) begin
          state_d  = ST_DONE;
          result_d = sc_result;
          err_d    = sc_err;
          valid_d  = 1'b1;
        end else if (state_q == ST_DONE && ready_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_ITER: if (md_done) state_d = ST_FIX;
      ST_FIX: begin
        state_d  = ST_DONE;
        result_d = fix_result;
        err_d    = fix_err;
        valid_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      neg_q     <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      div_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bz_q      <= 1'b0;
      a_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      neg_q     <= neg_d;
`ifdef ALU_ITER_DIV_EN
      div_q     <= div_d;
      rem_neg_q <= rem_neg_d;
      bz_q      <= bz_d;
      a_q       <= a_d;
`endif
    end
  end

  alu_iter_muldiv #(.WIDTH_P(W)) u_muldiv (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (md_start),
`ifdef ALU_ITER_DIV_EN
    .div_i    (op_in == OP_DIV),
`else
    .div_i    (1'b0),
`endif
    .signed_i (signed_i),
    .a_i      (operand_a_i),
    .b_i      (operand_b_i),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at WIDTH_P=32 plus a WIDTH_P=8 instance.
// Divide expectations follow whether ALU_ITER_DIV_EN is defined.
module tb_alu_iter;

  typedef struct {
    logic [2:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        err;
    int          lat;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        valid_i = 1'b0, signed_i = 1'b0, ready_i = 1'b0;
  logic [2:0]  opcode_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        ready_o, valid_o, err_o;
  logic [63:0] result_o;
  logic [1:0]  state_o;

  // 8-bit instance
  logic        s_valid_i = 1'b0, s_signed_i = 1'b0, s_ready_i = 1'b0;
  logic [2:0]  s_opcode_i = '0;
  logic [7:0]  s_a_i = '0, s_b_i = '0;
  logic        s_ready_o, s_valid_o, s_err_o;
  logic [15:0] s_result_o;
  logic [1:0]  s_state_o;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  alu_iter #(.WIDTH_P(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .opcode_i(opcode_i),
    .signed_i(signed_i), .operand_a_i(a_i), .operand_b_i(b_i), .ready_o(ready_o),
    .ready_i(ready_i), .valid_o(valid_o), .result_o(result_o), .err_o(err_o),
    .state_o(state_o)
  );

  alu_iter #(.WIDTH_P(8)) dut8 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(s_valid_i), .opcode_i(s_opcode_i),
    .signed_i(s_signed_i), .operand_a_i(s_a_i), .operand_b_i(s_b_i), .ready_o(s_ready_o),
    .ready_i(s_ready_i), .valid_o(s_valid_o), .result_o(s_result_o), .err_o(s_err_o),
    .state_o(s_state_o)
  );

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] op, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res, input logic err,
                         input int lat);
    vec_t v;
    v.op = op; v.sgn = sgn; v.a = a; v.b = b; v.res = res; v.err = err; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic add_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic err);
`ifdef ALU_ITER_DIV_EN
    add_vec(3'd3, sgn, a, b, res, err, 34);
`else
    add_vec(3'd3, sgn, a, b, 64'd0, 1'b1, 1);
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    opcode_i = v.op; signed_i = v.sgn; a_i = v.a; b_i = v.b;
    valid_i = 1'b1; ready_i = 1'b0;
    chk($sformatf("v%0d_ready", idx), 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    opcode_i = 3'($urandom_range(0, 7)); a_i = $urandom(); b_i = $urandom();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && v.lat > 1) chk($sformatf("v%0d_busy", idx), 64'(ready_o), 64'd0);
    end while (!valid_o && lat < 200);
    chk($sformatf("v%0d_lat", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d_res", idx), result_o, v.res);
    chk($sformatf("v%0d_err", idx), 64'(err_o), 64'(v.err));
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic run8(input string name, input logic [2:0] op, input logic sgn,
                      input logic [7:0] a, input logic [7:0] b, input logic [15:0] res,
                      input logic err, input int exp_lat);
    int lat;
    @(negedge clk);
    s_opcode_i = op; s_signed_i = sgn; s_a_i = a; s_b_i = b; s_valid_i = 1'b1;
    @(posedge clk); #1;
    s_valid_i = 1'b0; s_a_i = 8'($urandom()); s_b_i = 8'($urandom());
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_valid_o && lat < 100);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, 64'(s_result_o), 64'(res));
    chk({name, "_err"}, 64'(s_err_o), 64'(err));
    s_ready_i = 1'b1;
    @(posedge clk); #1;
    s_ready_i = 1'b0;
  endtask

  initial begin : main
    int lat;
    // vector table: op, signed, A, B, result, err, latency
    add_vec(3'd1, 1'b0, 32'hFFFFFFFF, 32'h1,        64'h00000001_00000000, 1'b0, 1);
    add_vec(3'd2, 1'b1, 32'hFFFFFFFD, 32'h7,        64'hFFFFFFFF_FFFFFFEB, 1'b0, 34);
    add_vec(3'd2, 1'b0, 32'hFFFFFFFD, 32'h7,        64'h00000006_FFFFFFEB, 1'b0, 34);
    add_div(1'b1, 32'hFFFFFFF9, 32'h2,              64'hFFFFFFFF_FFFFFFFD, 1'b0);
    add_div(1'b1, 32'h80000000, 32'hFFFFFFFF,       64'h00000000_80000000, 1'b0);
    add_div(1'b0, 32'h5,        32'h0,              64'h00000005_FFFFFFFF, 1'b1);
    add_vec(3'd4, 1'b1, 32'h3,        32'h5,        64'hFFFFFFFF_FFFFFFFE, 1'b0, 1);
    add_vec(3'd5, 1'b0, 32'hF0F01234, 32'h0FF0FFFF, 64'h00000000_00F01234, 1'b0, 1);
    add_vec(3'd6, 1'b1, 32'hF0000000, 32'h0000000F, 64'h00000000_F000000F, 1'b0, 1);
    add_vec(3'd7, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 64'h00000000_F0F00F0F, 1'b0, 1);
    add_vec(3'd0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 64'h0,                 1'b0, 1);
    add_vec(3'd1, 1'b1, 32'h7FFFFFFF, 32'h1,        64'h00000000_80000000, 1'b0, 1);
    add_vec(3'd1, 1'b1, 32'h80000000, 32'h80000000, 64'hFFFFFFFF_00000000, 1'b0, 1);
    add_vec(3'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000001_FFFFFFFE, 1'b0, 1);
    add_vec(3'd4, 1'b0, 32'h0,        32'h1,        64'hFFFFFFFF_FFFFFFFF, 1'b0, 1);
    add_vec(3'd2, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 34);
    add_vec(3'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, 34);
    add_vec(3'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 34);
    add_div(1'b0, 32'd100,      32'd7,              64'h00000002_0000000E, 1'b0);
    add_div(1'b1, 32'h7,        32'hFFFFFFFE,       64'h00000001_FFFFFFFD, 1'b0);
    add_div(1'b1, 32'hFFFFFFFB, 32'h0,              64'hFFFFFFFB_FFFFFFFF, 1'b1);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_result", result_o, 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    reset_i = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // hold a MUL result in DONE, then back-to-back SUB
    @(negedge clk);
    opcode_i = 3'd2; signed_i = 1'b0; a_i = 32'd6; b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_o && lat < 200);
    chk("hold_lat", 64'(lat), 64'd34);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), 64'(valid_o), 64'd1);
      chk($sformatf("hold%0d_res", c), result_o, 64'd42);
      chk($sformatf("hold%0d_err", c), 64'(err_o), 64'd0);
    end
    opcode_i = 3'd4; signed_i = 1'b0; a_i = 32'd3; b_i = 32'd5;
    valid_i = 1'b1; ready_i = 1'b1;
    #1;
    chk("b2b_ready", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(valid_o), 64'd1);
    chk("b2b_res", result_o, 64'hFFFFFFFF_FFFFFFFE);
    chk("b2b_err", 64'(err_o), 64'd0);

    // accept MUL out of DONE, reset in the middle of iteration
    opcode_i = 3'd2; a_i = 32'h1234; b_i = 32'h10; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("iter_state", 64'(state_o), 64'd1);
    chk("iter_valid", 64'(valid_o), 64'd0);
    reset_i = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    chk("arst_result", result_o, 64'd0);
    chk("arst_state", 64'(state_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;

    // narrow instance
    run8("w8_mul_u", 3'd2, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 1'b0, 10);
    run8("w8_mul_s", 3'd2, 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 10);
`ifdef ALU_ITER_DIV_EN
    run8("w8_div_s", 3'd3, 1'b1, 8'h80, 8'hFF, 16'h0080, 1'b0, 10);
`else
    run8("w8_div_s", 3'd3, 1'b1, 8'h80, 8'hFF, 16'h0000, 1'b1, 1);
`endif
    run8("w8_sub_s", 3'd4, 1'b1, 8'h80, 8'h01, 16'hFF7F, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
